// File: rtl/press_judge.sv
// Button synchronizer, debouncer and press judge with lockout and streak tracking.
// Optional macro PRESS_JUDGE_LOCK_TIMEOUT_EN adds a LOCK timeout counter.
module press_judge #(
   parameter int unsigned DB_CYCLES    = 500000,
   parameter int unsigned STREAK_W     = 8,
   parameter int unsigned LOCK_TIMEOUT = 50000000
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                BTN,
   input  logic [7:0]          LEDS,
   input  logic [7:0]          SW,
   output logic                HIT,
   output logic                MISS,
   output logic [STREAK_W-1:0] STREAK,
   output logic [STREAK_W-1:0] BEST,
   output logic                BUSY
);

   localparam int unsigned DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      JUDGE,
      LOCK
   } state_t;

   logic                sync1_q, sync1_d;
   logic                sync2_q, sync2_d;
   logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
   logic                db_lvl_q, db_lvl_d;
   logic                db_prev_q, db_prev_d;
   logic                rel_q, rel_d;
   state_t              state_q, state_d;
   logic [7:0]          cap_led_q, cap_led_d;
   logic [7:0]          cap_sw_q, cap_sw_d;
   logic                hit_q, hit_d;
   logic                miss_q, miss_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic [STREAK_W-1:0] best_q, best_d;
   logic                busy_q, busy_d;
   logic                lock_done;

`ifdef PRESS_JUDGE_LOCK_TIMEOUT_EN
   localparam int unsigned LK_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
   localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCK_TIMEOUT - 1);
   logic [LK_W-1:0] lock_cnt_q, lock_cnt_d;

   always_comb begin
      lock_cnt_d = (state_q == LOCK) ? lock_cnt_q + 1'b1 : '0;
      lock_done  = (state_q == LOCK) && (lock_cnt_q == LK_LAST);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) lock_cnt_q <= '0;
      else     lock_cnt_q <= lock_cnt_d;
   end
`else
   always_comb lock_done = 1'b0;
`endif

   // Conditioning path: 2-flop sync, debounce, registered release strobe
   always_comb begin
      sync1_d   = BTN;
      sync2_d   = sync1_q;
      db_lvl_d  = db_lvl_q;
      db_cnt_d  = '0;
      if (sync2_q != db_lvl_q) begin
         if (db_cnt_q == DB_LAST) db_lvl_d = sync2_q;
         else                     db_cnt_d = db_cnt_q + 1'b1;
      end
      db_prev_d = db_lvl_q;
      rel_d     = db_prev_q & ~db_lvl_q;
   end

   always_comb begin
      state_d   = state_q;
      cap_led_d = cap_led_q;
      cap_sw_d  = cap_sw_q;
      hit_d     = 1'b0;
      miss_d    = 1'b0;
      streak_d  = streak_q;
      best_d    = (streak_q > best_q) ? streak_q : best_q;
      case (state_q)
         IDLE: begin
            if (rel_q) begin
               cap_led_d = LEDS;
               cap_sw_d  = SW;
               state_d   = JUDGE;
            end
         end
         JUDGE: begin
            if ((cap_sw_q == cap_led_q) && (cap_led_q != '0)) begin
               hit_d    = 1'b1;
               streak_d = (streak_q == '1) ? streak_q : streak_q + 1'b1;
            end else begin
               miss_d   = 1'b1;
               streak_d = '0;
            end
            state_d = LOCK;
         end
         LOCK: begin
            if ((LEDS != cap_led_q) || lock_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         db_cnt_q  <= '0;
         db_lvl_q  <= 1'b0;
         db_prev_q <= 1'b0;
         rel_q     <= 1'b0;
         state_q   <= IDLE;
         cap_led_q <= '0;
         cap_sw_q  <= '0;
         hit_q     <= 1'b0;
         miss_q    <= 1'b0;
         streak_q  <= '0;
         best_q    <= '0;
         busy_q    <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         db_cnt_q  <= db_cnt_d;
         db_lvl_q  <= db_lvl_d;
         db_prev_q <= db_prev_d;
         rel_q     <= rel_d;
         state_q   <= state_d;
         cap_led_q <= cap_led_d;
         cap_sw_q  <= cap_sw_d;
         hit_q     <= hit_d;
         miss_q    <= miss_d;
         streak_q  <= streak_d;
         best_q    <= best_d;
         busy_q    <= busy_d;
      end
   end

   assign HIT    = hit_q;
   assign MISS   = miss_q;
   assign STREAK = streak_q;
   assign BEST   = best_q;
   assign BUSY   = busy_q;

endmodule

// File: tb/tb_press_judge.sv
// Self-checking bench for press_judge: vector table, corner sequences, and
// randomized presses checked cycle-by-cycle against an event-timeline model.
module tb_press_judge;

   localparam int DB = 4;
   localparam int LT = 16;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       BTN = 1'b0;
   logic [7:0] LEDS = '0;
   logic [7:0] SW = '0;
   logic       HIT, MISS, BUSY;
   logic [7:0] STREAK, BEST;

   int checks = 0;
   int failures = 0;

   press_judge #(.DB_CYCLES(DB), .STREAK_W(8), .LOCK_TIMEOUT(LT)) dut (
      .CLK(CLK), .RST(RST), .BTN(BTN), .LEDS(LEDS), .SW(SW),
      .HIT(HIT), .MISS(MISS), .STREAK(STREAK), .BEST(BEST), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   // Reference model: edge-indexed timeline of debounced releases and judgements
   int         edge_n = 0;
   bit         pipe[$];
   int         m_run;
   bit         m_prev_bs, m_lvl;
   int         rel_m[$];
   bit         m_locked;
   int         cap_edge;
   logic [7:0] cap_led, cap_sw;
   bit         m_hit, m_miss;
   int         m_streak, m_best;

   task automatic model_reset();
      pipe = {1'b0, 1'b0};
      m_run = 0; m_prev_bs = 0; m_lvl = 0;
      rel_m.delete();
      m_locked = 0; cap_edge = -100; cap_led = '0; cap_sw = '0;
      m_hit = 0; m_miss = 0; m_streak = 0; m_best = 0;
   endtask

   task automatic model_step();
      bit bs, locked_n, hit_n, miss_n, timed_out;
      int streak_n, best_n;
      edge_n++;
      bs = pipe.pop_front();
      pipe.push_back(BTN);
      hit_n = 0; miss_n = 0;
      best_n = (m_streak > m_best) ? m_streak : m_best;
      streak_n = m_streak;
      locked_n = m_locked;
`ifdef PRESS_JUDGE_LOCK_TIMEOUT_EN
      timed_out = (edge_n == cap_edge + 1 + LT);
`else
      timed_out = 0;
`endif
      if (m_locked && edge_n == cap_edge + 1) begin
         if (cap_sw == cap_led && cap_led != 0) begin
            hit_n = 1;
            streak_n = (m_streak < 255) ? m_streak + 1 : 255;
         end else begin
            miss_n = 1;
            streak_n = 0;
         end
      end else if (m_locked && (LEDS != cap_led || timed_out)) begin
         locked_n = 0;
      end
      while (rel_m.size() > 0 && rel_m[0] + 2 < edge_n) void'(rel_m.pop_front());
      if (rel_m.size() > 0 && rel_m[0] + 2 == edge_n) begin
         void'(rel_m.pop_front());
         if (!m_locked) begin
            cap_led = LEDS; cap_sw = SW; cap_edge = edge_n; locked_n = 1;
         end
      end
      // a new level is adopted once the synchronized button has held it DB cycles
      if (bs == m_prev_bs) m_run++;
      else m_run = 1;
      m_prev_bs = bs;
      if (bs != m_lvl && m_run >= DB) begin
         m_lvl = bs;
         if (!bs) rel_m.push_back(edge_n);
      end
      m_hit = hit_n; m_miss = miss_n;
      m_streak = streak_n; m_best = best_n;
      m_locked = locked_n;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      if (RST) model_reset();
      else model_step();
      #1;
      chk("HIT", HIT, m_hit);
      chk("MISS", MISS, m_miss);
      chk("STREAK", STREAK, m_streak);
      chk("BEST", BEST, m_best);
      chk("BUSY", BUSY, m_locked);
      chk("HIT_MISS_EXCL", HIT & MISS, 0);
   endtask

   task automatic press(input int hold, input int gap, output int nh, output int nm);
      nh = 0; nm = 0;
      BTN = 1'b1;
      for (int i = 0; i < hold; i++) begin tick(); nh += HIT; nm += MISS; end
      BTN = 1'b0;
      for (int i = 0; i < gap; i++) begin tick(); nh += HIT; nm += MISS; end
   endtask

   typedef struct {
      logic [7:0] leds;
      logic [7:0] sw;
      int         hold;
      int         hits;
      int         misses;
      int         streak;
      int         best;
   } vec_t;

   vec_t tbl[10];

   initial begin
      int nh, nm;
      tbl[0] = '{8'h10, 8'h10, 10, 1, 0, 1, 1};
      tbl[1] = '{8'h10, 8'h10, 10, 0, 0, 1, 1};
      tbl[2] = '{8'h20, 8'h20, 10, 1, 0, 2, 2};
      tbl[3] = '{8'h40, 8'h04, 10, 0, 1, 0, 2};
      tbl[4] = '{8'h00, 8'h00, 10, 0, 1, 0, 2};
      tbl[5] = '{8'h80, 8'h80,  5, 1, 0, 1, 2};
      tbl[6] = '{8'h01, 8'h01,  3, 0, 0, 1, 2};
      tbl[7] = '{8'h01, 8'h01,  2, 0, 0, 1, 2};
      tbl[8] = '{8'h01, 8'h01,  1, 0, 0, 1, 2};
      tbl[9] = '{8'h01, 8'h01,  4, 1, 0, 2, 2};

      model_reset();
      tick(); tick();
      RST = 1'b0;
      for (int i = 0; i < 20; i++) tick();

      foreach (tbl[k]) begin
         LEDS = tbl[k].leds;
         SW   = tbl[k].sw;
         press(tbl[k].hold, 16, nh, nm);
         chk($sformatf("tbl%0d_hits", k), nh, tbl[k].hits);
         chk($sformatf("tbl%0d_misses", k), nm, tbl[k].misses);
         chk($sformatf("tbl%0d_streak", k), STREAK, tbl[k].streak);
         chk($sformatf("tbl%0d_best", k), BEST, tbl[k].best);
      end

      // Press begun during LOCK, released after LEDS moved on: accepted
      LEDS = 8'h04; SW = 8'h04;
      press(6, 16, nh, nm);
      chk("lock_setup_hits", nh, 1);
      BTN = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      LEDS = 8'h08; SW = 8'h08;
      for (int i = 0; i < 4; i++) tick();
      press(0, 16, nh, nm);
      chk("rel_in_idle_hits", nh, 1);
      chk("rel_in_idle_streak", STREAK, 4);

      // Asynchronous reset in the middle of LOCK
      LEDS = 8'h02; SW = 8'h02;
      press(6, 16, nh, nm);
      chk("pre_reset_busy", BUSY, 1);
      #2 RST = 1'b1;
      model_reset();
      #1;
      chk("async_rst_hit", HIT, 0);
      chk("async_rst_streak", STREAK, 0);
      chk("async_rst_best", BEST, 0);
      chk("async_rst_busy", BUSY, 0);
      tick(); tick();
      RST = 1'b0;
      for (int i = 0; i < 5; i++) tick();

      // Frozen LED pattern after a hit
      LEDS = 8'h20; SW = 8'h20;
      press(6, 40, nh, nm);
      chk("frozen_first_hits", nh, 1);
`ifdef PRESS_JUDGE_LOCK_TIMEOUT_EN
      chk("frozen_busy_timeout", BUSY, 0);
      press(6, 16, nh, nm);
      chk("frozen_second_hits", nh, 1);
`else
      chk("frozen_busy_held", BUSY, 1);
      press(6, 16, nh, nm);
      chk("frozen_second_hits", nh, 0);
`endif

      for (int it = 0; it < 200; it++) begin
         int hold, gap;
         if ($urandom_range(0, 2) == 0) begin
            LEDS = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'(8'h01 << $urandom_range(0, 7));
            SW = ($urandom_range(0, 1) == 0) ? LEDS : 8'($urandom);
         end
         hold = $urandom_range(1, 8);
         gap  = $urandom_range(1, 12);
         BTN = 1'b1;
         for (int i = 0; i < hold; i++) begin
            if ($urandom_range(0, 9) == 0) LEDS = 8'(8'h01 << $urandom_range(0, 7));
            tick();
         end
         BTN = 1'b0;
         for (int i = 0; i < gap; i++) begin
            if ($urandom_range(0, 19) == 0) begin
               LEDS = 8'($urandom);
               SW = 8'($urandom);
            end
            tick();
         end
      end
      for (int i = 0; i < 20; i++) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
